// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch path: default bus widths and
// the FSM state encoding reported on the debug port.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_RSVD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the program ROM, the decoder redirect
// and the downstream instruction consumer.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid,
        input  rom_data, load, load_addr, instr_ready
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid,
        output rom_data, load, load_addr, instr_ready
    );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: redirect load has priority over increment; the increment
// wraps naturally at 2^ADDR_W.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC drives a combinational ROM, the returned word is
// registered with its address and handed downstream over a valid/ready pair.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [1:0]   state,
    fetch_unit_if.master bus
);

    logic [ADDR_W-1:0] w_pc;
    logic              w_transfer;
    logic              w_capture;
    logic              w_stalled;

    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_valid;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;

    assign w_transfer = r_valid & bus.instr_ready;
    assign w_capture  = en & ~bus.load & (~r_valid | w_transfer);
    // A held word with no consumer and no flush freezes the whole pipeline.
    assign w_stalled  = r_valid & ~bus.instr_ready & ~bus.load;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (bus.load),
        .i_load_addr (bus.load_addr),
        .i_inc       (w_capture),
        .o_pc        (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else if (bus.load) begin
            r_valid    <= 1'b0;
        end else if (w_capture) begin
            r_instr    <= bus.rom_data;
            r_instr_pc <= w_pc;
            r_valid    <= 1'b1;
        end else if (w_transfer) begin
            r_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_RUN, ST_STALL: begin
                if (w_stalled) begin
                    w_state_next = ST_STALL;
                end else if (en) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.rom_addr    = w_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign state           = r_state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 12, program-memory address width.
REQ-002 Parameter DATA_W, default 8, program-memory word width.
REQ-003 Parameter RESET_PC, default 12'h000, PC value after reset.
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  fetch enable.
REQ-007 Port rom_addr  output  ADDR_W  address to combinational program ROM.
REQ-008 Port rom_data  input  DATA_W  ROM word for rom_addr, same cycle.
REQ-009 Port load  input  1  redirect request (jump) from decoder.
REQ-010 Port load_addr  input  ADDR_W  redirect target.
REQ-011 Port instr  output  DATA_W  registered fetched word.
REQ-012 Port instr_pc  output  ADDR_W  address instr was fetched from.
REQ-013 Port instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-014 Port instr_ready  input  1  downstream consumes instr this cycle.
REQ-015 Port state  output  2  current FSM state, for debug.

Function
REQ-016 The block SHALL hold a registered PC and drive rom_addr = PC combinationally from that register.
REQ-017 The FSM SHALL have states IDLE=0, RUN=1, STALL=2; state 3 unused, recovers to IDLE.
REQ-018 Handshake: a transfer SHALL occur on a cycle where instr_valid=1 and instr_ready=1.
REQ-019 Capture condition SHALL be en=1, load=0, and (instr_valid=0 or transfer); on capture instr<=rom_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-020 PC increment SHALL wrap modulo 2^ADDR_W (12'hFFF -> 12'h000), no flag, no stall.
REQ-021 When instr_valid=1 and instr_ready=0, instr, instr_pc, PC and rom_addr SHALL stay constant; FSM SHALL be STALL.
REQ-022 When en=0 and no capture: a transfer SHALL clear instr_valid; otherwise outputs hold; FSM SHALL be IDLE.
REQ-023 FSM transitions: IDLE->RUN on en=1; RUN->STALL on valid&!ready; STALL->RUN on ready; any->IDLE on en=0 with no pending word.
REQ-024 load=1 SHALL take priority over all: PC<=load_addr, instr_valid<=0 (flush, pending word discarded), regardless of instr_ready or en.
REQ-025 Latency: load at edge n SHALL give rom_addr=load_addr after n, and instr_valid=1 with instr_pc=load_addr after n+1 if en=1 and load deasserted.
REQ-026 Sustained throughput SHALL be one word per cycle with instr_ready held 1.
REQ-027 load and transfer in the same cycle: transfer counts as consumed, then flush per REQ-024.

Reset
REQ-028 On rst_n=0, immediately: PC=RESET_PC, rom_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, state=IDLE.
REQ-029 Reset mid-operation SHALL discard any pending word; first capture after release SHALL be from RESET_PC.

Structure
REQ-030 ADDR_W, DATA_W defaults and FSM state encodings SHALL live in the shared project constants file.
REQ-031 One sub-module pc_reg (load/increment/hold, wrap) SHALL be instantiated; FSM and output register stay in fetch_unit.
REQ-032 The bench SHALL connect the existing project ROM (12-bit address, 8-bit data) to rom_addr/rom_data.

Verification
REQ-033 Reset: rst_n=0 -> rom_addr=000, instr_valid=0, state=0; release with en=0 -> unchanged.
REQ-034 Stream: en=1, ready=1 -> instr_pc 000,001,002,003 on consecutive cycles, instr = ROM[instr_pc].
REQ-035 Backpressure: ready=0 for 3 cycles at instr_pc=002 -> instr, instr_pc=002, rom_addr=003 stable, state=2; ready=1 -> 003 next.
REQ-036 Jump: load=1, load_addr=ABC while valid word pending -> next cycle instr_valid=0; following cycle instr_pc=ABC.
REQ-037 Wrap: load FFE -> instr_pc FFE, FFF, 000, 001.
REQ-038 Async reset mid-stream at instr_pc=005 -> outputs reset without clock edge; restart at 000.
